vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- CREDIT_W, 8, credit/coin/change width.
- N_ITEMS, 4, number of selectable products.
- PRICE, 25, price of every product in credit units.
- STOCK_INIT, 7, per-item stock after reset or restock.
- TIMEOUT, 16, cycles DISPENSE waits for received.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- coin_valid, in, 1, coin present this cycle.
- coin_value, in, CREDIT_W, value of the coin.
- cancel, in, 1, customer refund request.
- sel_valid, in, 1, selection strobe.
- sel_id, in, $clog2(N_ITEMS), selected item.
- received, in, 1, customer took the drink.
- restock, in, 1, reload all stock counters.
- flash, out, 1, "insert coin" lamp.
- drink_valid, out, 1, drink being dispensed.
- drink_id, out, $clog2(N_ITEMS), item being dispensed.
- change_valid, out, 1, change-return strobe.
- change_amount, out, CREDIT_W, change value.
- coin_reject, out, 1, coin returned (overflow or wrong state).
- sel_err, out, 1, selection refused.
- credit, out, CREDIT_W, current credit.

REQ-003 Only clk and reset SHALL be clock and reset; reset is synchronous and active-high.

Function
REQ-004 States SHALL be IDLE, CREDIT, DISPENSE and REFUND; all outputs are registered or decoded from registered state, and every input is acted on with 1-cycle latency.
REQ-005 IDLE: flash=1; coin_valid with coin_value>0 -> credit=coin_value, go to CREDIT; coin_value=0 is ignored; cancel and sel_valid are ignored.
REQ-006 Coin accept, any state except REFUND: credit+coin_value <= 2^CREDIT_W-1 -> added; otherwise credit unchanged and coin_reject=1 for 1 cycle.
REQ-007 Coins in REFUND SHALL be rejected with coin_reject=1 for 1 cycle.
REQ-008 CREDIT priority order: cancel > sel_valid; a coin in the same cycle is added first, then the selected action uses the summed credit.
REQ-009 CREDIT+cancel -> REFUND.
REQ-010 CREDIT+sel_valid, credit>=PRICE and stock[sel_id]>0 -> credit-=PRICE, stock[sel_id]-=1, latch drink_id=sel_id, go to DISPENSE.
REQ-011 CREDIT+sel_valid with insufficient credit, zero stock, or sel_id>=N_ITEMS -> sel_err=1 for 1 cycle, stay in CREDIT, no state change.
REQ-012 DISPENSE: drink_valid=1 and drink_id held stable; cancel and sel_valid are ignored; coins are accepted per REQ-006.
REQ-013 DISPENSE+received -> REFUND if credit>0, else IDLE.
REQ-014 DISPENSE timeout: TIMEOUT consecutive cycles without received -> credit+=PRICE (saturating at 2^CREDIT_W-1), stock not restored, go to REFUND.
REQ-015 REFUND SHALL last exactly 1 cycle: change_valid=1 and change_amount=credit, credit cleared to 0, next state IDLE.
REQ-016 change_amount SHALL be 0 whenever change_valid=0.
REQ-017 restock, any state: all stock counters = STOCK_INIT next cycle; if a decrement coincides, restock wins.
REQ-018 The timeout counter SHALL clear on entry to DISPENSE and SHALL be $clog2(TIMEOUT+1) bits wide.

Reset
REQ-019 reset SHALL force: state=IDLE, credit=0, every stock=STOCK_INIT, flash=1, all other outputs 0.
REQ-020 reset mid-DISPENSE or mid-REFUND SHALL discard credit with no change_valid pulse, and reset dominates all inputs in the same cycle.

Structure
REQ-021 Package vend_pkg SHALL hold the state_t enum (2 bits) and default parameter constants.
REQ-022 Sub-module vend_stock SHALL implement the N_ITEMS stock counters with restock, decrement and a per-item empty flag.

Verification
REQ-023 Verification SHALL cover these directed scenarios (PRICE=25):
- Coins 10, 10, 10 then sel_id=2 -> DISPENSE, drink_id=2, credit=5; received -> change_valid with change_amount=5, then IDLE, flash=1.
- Coin 10 then sel -> sel_err 1 cycle, credit stays 10; cancel -> change_amount=10.
- Same-cycle coin 20 and cancel with credit 10 -> change_amount=30.
- Credit 250 plus coin 10 (CREDIT_W=8) -> coin_reject, credit stays 250.
- Eight purchases of item 0 -> eighth gives sel_err (stock 0); restock -> ninth purchase succeeds.
- No received for 16 cycles in DISPENSE -> REFUND, change_amount=leftover+25; reset asserted mid-DISPENSE -> IDLE, credit 0, no change_valid.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared state encoding and default parameters for the vending machine controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  localparam int CREDIT_W_DEF   = 8;
  localparam int N_ITEMS_DEF    = 4;
  localparam int PRICE_DEF      = 25;
  localparam int STOCK_INIT_DEF = 7;
  localparam int TIMEOUT_DEF    = 16;

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters: reload on restock, single decrement per cycle, empty flags.
module vend_stock
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = N_ITEMS_DEF,
  parameter int STOCK_INIT = STOCK_INIT_DEF,
  parameter int SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restock,
  input  logic               dec_valid,
  input  logic [SEL_W-1:0]   dec_id,
  output logic [N_ITEMS-1:0] empty
);

  localparam int CNT_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(STOCK_INIT);

  logic [CNT_W-1:0] stock_r [N_ITEMS];

  // Counter update; restock overrides a coincident decrement
  always_ff @(posedge clk) begin
    if (reset || restock) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_r[i] <= INIT_C;
      end
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (dec_valid && (dec_id == SEL_W'(i)) && (stock_r[i] != {CNT_W{1'b0}})) begin
          stock_r[i] <= stock_r[i] - CNT_W'(1);
        end
      end
    end
  end

  // Empty flags decoded from the registered counters
  always_comb begin
    empty = {N_ITEMS{1'b0}};
    for (int i = 0; i < N_ITEMS; i++) begin
      empty[i] = (stock_r[i] == {CNT_W{1'b0}});
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, selection, dispense with timeout, and refund.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = CREDIT_W_DEF,
  parameter int N_ITEMS    = N_ITEMS_DEF,
  parameter int PRICE      = PRICE_DEF,
  parameter int STOCK_INIT = STOCK_INIT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  localparam int SEL_W     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                cancel,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                received,
  input  logic                restock,
  output logic                flash,
  output logic                drink_valid,
  output logic [SEL_W-1:0]    drink_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                coin_reject,
  output logic                sel_err,
  output logic [CREDIT_W-1:0] credit
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [SEL_W:0]      N_ITEMS_C  = (SEL_W + 1)'(N_ITEMS);

  state_t              state_r, state_nxt_s;
  logic [CREDIT_W-1:0] credit_r, credit_nxt_s;
  logic [SEL_W-1:0]    drink_id_r, drink_id_nxt_s;
  logic [TMO_W-1:0]    tmo_r, tmo_nxt_s;
  logic                coin_reject_r, coin_reject_nxt_s;
  logic                sel_err_r, sel_err_nxt_s;
  logic [CREDIT_W:0]   coin_sum_s, tmo_sum_s;
  logic [CREDIT_W-1:0] acc_s, tmo_credit_s;
  logic                sel_ok_s;
  logic                dec_valid_s;
  logic [N_ITEMS-1:0]  empty_s;

  vend_stock #(
    .N_ITEMS    (N_ITEMS),
    .STOCK_INIT (STOCK_INIT),
    .SEL_W      (SEL_W)
  ) u_stock (
    .clk       (clk),
    .reset     (reset),
    .restock   (restock),
    .dec_valid (dec_valid_s),
    .dec_id    (sel_id),
    .empty     (empty_s)
  );

  // Credit datapath: coin added first, saturating timeout credit, purchase eligibility
  always_comb begin
    coin_sum_s = {1'b0, credit_r} + {1'b0, coin_value};
    if (coin_valid && !coin_sum_s[CREDIT_W]) begin
      acc_s = coin_sum_s[CREDIT_W-1:0];
    end else begin
      acc_s = credit_r;
    end
    tmo_sum_s = {1'b0, acc_s} + {1'b0, PRICE_C};
    if (tmo_sum_s[CREDIT_W]) begin
      tmo_credit_s = CREDIT_MAX;
    end else begin
      tmo_credit_s = tmo_sum_s[CREDIT_W-1:0];
    end
    if ({1'b0, sel_id} < N_ITEMS_C) begin
      sel_ok_s = !empty_s[sel_id] && (acc_s >= PRICE_C);
    end else begin
      sel_ok_s = 1'b0;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_nxt_s       = state_r;
    credit_nxt_s      = credit_r;
    drink_id_nxt_s    = drink_id_r;
    tmo_nxt_s         = tmo_r;
    coin_reject_nxt_s = coin_valid && coin_sum_s[CREDIT_W];
    sel_err_nxt_s     = 1'b0;
    dec_valid_s       = 1'b0;
    case (state_r)
      IDLE: begin
        credit_nxt_s = acc_s;
        if (coin_valid && (coin_value != {CREDIT_W{1'b0}})) begin
          state_nxt_s = CREDIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CREDIT: begin
        credit_nxt_s = acc_s;
        if (cancel) begin
          state_nxt_s = REFUND;
        end else if (sel_valid) begin
          if (sel_ok_s) begin
            credit_nxt_s   = acc_s - PRICE_C;
            dec_valid_s    = 1'b1;
            drink_id_nxt_s = sel_id;
            tmo_nxt_s      = {TMO_W{1'b0}};
            state_nxt_s    = DISPENSE;
          end else begin
            sel_err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = CREDIT;
        end
      end
      DISPENSE: begin
        credit_nxt_s = acc_s;
        tmo_nxt_s    = tmo_r + TMO_W'(1);
        if (received) begin
          if (acc_s != {CREDIT_W{1'b0}}) begin
            state_nxt_s = REFUND;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (tmo_r == TMO_LAST) begin
          credit_nxt_s = tmo_credit_s;
          state_nxt_s  = REFUND;
        end else begin
          state_nxt_s = DISPENSE;
        end
      end
      REFUND: begin
        coin_reject_nxt_s = coin_valid;
        credit_nxt_s      = {CREDIT_W{1'b0}};
        state_nxt_s       = IDLE;
      end
      default: begin
        credit_nxt_s = {CREDIT_W{1'b0}};
        state_nxt_s  = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      credit_r      <= {CREDIT_W{1'b0}};
      drink_id_r    <= {SEL_W{1'b0}};
      tmo_r         <= {TMO_W{1'b0}};
      coin_reject_r <= 1'b0;
      sel_err_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      credit_r      <= credit_nxt_s;
      drink_id_r    <= drink_id_nxt_s;
      tmo_r         <= tmo_nxt_s;
      coin_reject_r <= coin_reject_nxt_s;
      sel_err_r     <= sel_err_nxt_s;
    end
  end

  assign flash         = (state_r == IDLE);
  assign drink_valid   = (state_r == DISPENSE);
  assign drink_id      = drink_valid ? drink_id_r : {SEL_W{1'b0}};
  assign change_valid  = (state_r == REFUND);
  assign change_amount = change_valid ? credit_r : {CREDIT_W{1'b0}};
  assign coin_reject   = coin_reject_r;
  assign sel_err       = sel_err_r;
  assign credit        = credit_r;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed table, corner sequences, random run vs reference model.
module tb_vend_ctrl;

  localparam int CW = 8, NI = 4, PR = 25, SI = 7, TO = 16;
  localparam int CMAX = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, coin_valid, cancel, sel_valid, received, restock;
  logic [7:0] coin_value;
  logic [1:0] sel_id;
  logic       flash, drink_valid, change_valid, coin_reject, sel_err;
  logic [1:0] drink_id;
  logic [7:0] change_amount, credit;

  vend_ctrl #(.CREDIT_W(CW), .N_ITEMS(NI), .PRICE(PR), .STOCK_INIT(SI), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .cancel(cancel), .sel_valid(sel_valid), .sel_id(sel_id), .received(received),
    .restock(restock), .flash(flash), .drink_valid(drink_valid), .drink_id(drink_id),
    .change_valid(change_valid), .change_amount(change_amount), .coin_reject(coin_reject),
    .sel_err(sel_err), .credit(credit)
  );

  // Reference model: machine phase, credit and stock as plain integers
  typedef enum {M_IDLE, M_CREDIT, M_DISP, M_REF} mode_t;
  mode_t m_mode;
  int    m_credit, m_drink, m_waited;
  int    m_stock[NI];
  bit    m_rej, m_serr;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_step(bit rst, bit cv, int val, bit can, bit sv, int id, bit rcv, bit rs);
    int c;
    m_rej  = 0;
    m_serr = 0;
    if (rst) begin
      m_mode = M_IDLE;
      m_credit = 0;
      m_drink = 0;
      for (int i = 0; i < NI; i++) m_stock[i] = SI;
      return;
    end
    c = m_credit;
    if (cv) begin
      if (m_mode == M_REF) m_rej = 1;
      else if (c + val <= CMAX) c = c + val;
      else m_rej = 1;
    end
    case (m_mode)
      M_IDLE: begin
        m_credit = c;
        if (cv && val > 0) m_mode = M_CREDIT;
      end
      M_CREDIT: begin
        m_credit = c;
        if (can) m_mode = M_REF;
        else if (sv) begin
          if (c >= PR && id < NI && m_stock[id] > 0) begin
            m_credit = c - PR;
            m_stock[id]--;
            m_drink = id;
            m_waited = 0;
            m_mode = M_DISP;
          end else m_serr = 1;
        end
      end
      M_DISP: begin
        m_credit = c;
        if (rcv) m_mode = (c > 0) ? M_REF : M_IDLE;
        else begin
          m_waited++;
          if (m_waited == TO) begin
            m_credit = (c + PR > CMAX) ? CMAX : c + PR;
            m_mode = M_REF;
          end
        end
      end
      default: begin
        m_credit = 0;
        m_mode = M_IDLE;
      end
    endcase
    if (rs) for (int i = 0; i < NI; i++) m_stock[i] = SI;
  endfunction

  task automatic check_model();
    chk("flash", flash, m_mode == M_IDLE);
    chk("drink_valid", drink_valid, m_mode == M_DISP);
    chk("drink_id", drink_id, (m_mode == M_DISP) ? m_drink : 0);
    chk("change_valid", change_valid, m_mode == M_REF);
    chk("change_amount", change_amount, (m_mode == M_REF) ? m_credit : 0);
    chk("coin_reject", coin_reject, m_rej);
    chk("sel_err", sel_err, m_serr);
    chk("credit", credit, m_credit);
  endtask

  task automatic drive(input bit rst, input bit cv, input int val, input bit can,
                       input bit sv, input int id, input bit rcv, input bit rs);
    reset = rst; coin_valid = cv; coin_value = 8'(val); cancel = can;
    sel_valid = sv; sel_id = 2'(id); received = rcv; restock = rs;
    @(posedge clk);
    model_step(rst, cv, val, can, sv, id, rcv, rs);
    #1;
    check_model();
  endtask

  task automatic idle1();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit rst; bit cv; int val; bit can; bit sv; int id; bit rcv; bit rs;
    bit e_flash; bit e_dv; int e_did; bit e_cv; int e_camt; bit e_rej; bit e_serr; int e_credit;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit cv, int val, bit can, bit sv, int id, bit rcv, bit rs,
                              bit fl, bit dv, int did, bit chv, int camt, bit rej, bit serr, int cr);
    vec_t v;
    v.rst = rst; v.cv = cv; v.val = val; v.can = can; v.sv = sv; v.id = id; v.rcv = rcv; v.rs = rs;
    v.e_flash = fl; v.e_dv = dv; v.e_did = did; v.e_cv = chv; v.e_camt = camt;
    v.e_rej = rej; v.e_serr = serr; v.e_credit = cr;
    return v;
  endfunction

  initial begin
    int v, pick;
    int coin_tab[6] = '{0, 5, 10, 25, 50, 200};

    //          rst cv val can sv id rcv rs | fl dv did cv camt rej serr credit
    tbl.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 10));
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 20));
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 30));
    tbl.push_back(mk(0, 0,  0, 0, 1, 2, 0, 0,  0, 1, 2, 0,  0, 0, 0,  5));
    tbl.push_back(mk(0, 0,  0, 1, 1, 1, 0, 0,  0, 1, 2, 0,  0, 0, 0,  5));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0, 1, 0,  0, 0, 0, 1,  5, 0, 0,  5));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 10));
    tbl.push_back(mk(0, 0,  0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 1, 10));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 10));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 10, 0, 0, 10));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 10));
    tbl.push_back(mk(0, 1, 20, 1, 0, 0, 0, 0,  0, 0, 0, 1, 30, 0, 0, 30));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(0, 1,  0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  0));
    tbl.push_back(mk(0, 0,  0, 1, 1, 3, 0, 0,  1, 0, 0, 0,  0, 0, 0,  0));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].cv, tbl[k].val, tbl[k].can, tbl[k].sv, tbl[k].id, tbl[k].rcv, tbl[k].rs);
      chk("tbl_flash", flash, tbl[k].e_flash);
      chk("tbl_drink_valid", drink_valid, tbl[k].e_dv);
      chk("tbl_drink_id", drink_id, tbl[k].e_did);
      chk("tbl_change_valid", change_valid, tbl[k].e_cv);
      chk("tbl_change_amount", change_amount, tbl[k].e_camt);
      chk("tbl_coin_reject", coin_reject, tbl[k].e_rej);
      chk("tbl_sel_err", sel_err, tbl[k].e_serr);
      chk("tbl_credit", credit, tbl[k].e_credit);
    end

    // Overflow boundary and coins during refund
    drive(0, 1, 250, 0, 0, 0, 0, 0);
    drive(0, 1, 10, 0, 0, 0, 0, 0);
    chk("ovf_reject", coin_reject, 1);
    chk("ovf_credit_kept", credit, 250);
    drive(0, 1, 5, 0, 0, 0, 0, 0);
    chk("max_accept", credit, 255);
    chk("max_no_reject", coin_reject, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    chk("max_refund", change_amount, 255);
    drive(0, 1, 5, 0, 0, 0, 0, 0);
    chk("refund_coin_reject", coin_reject, 1);
    chk("refund_then_idle", flash, 1);
    idle1();

    // Stock exhaustion on item 0, then restock
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < SI; n++) begin
      drive(0, 1, 25, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
    end
    drive(0, 1, 25, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("empty_sel_err", sel_err, 1);
    chk("empty_no_dispense", drink_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("restock_dispense", drink_valid, 1);
    chk("restock_drink_id", drink_id, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("recv_zero_credit_idle", flash, 1);

    // Dispense timeout with a coin inserted while waiting
    drive(0, 1, 30, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    for (int n = 1; n < TO; n++) begin
      if (n == 5) drive(0, 1, 5, 0, 0, 0, 0, 0);
      else idle1();
    end
    chk("tmo_still_dispensing", drink_valid, 1);
    idle1();
    chk("tmo_refund", change_valid, 1);
    chk("tmo_amount", change_amount, 35);
    idle1();

    // Reset in the middle of a dispense
    drive(0, 1, 25, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 3, 0, 0);
    drive(0, 1, 10, 0, 0, 0, 0, 0);
    chk("pre_reset_credit", credit, 10);
    drive(1, 1, 10, 1, 1, 2, 1, 0);
    chk("rst_flash", flash, 1);
    chk("rst_credit", credit, 0);
    chk("rst_no_change", change_valid, 0);
    idle1();
    chk("rst_still_no_change", change_valid, 0);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      pick = $urandom_range(5, 0);
      v = coin_tab[pick];
      drive(($urandom_range(99, 0) < 1), ($urandom_range(99, 0) < 30), v,
            ($urandom_range(99, 0) < 5), ($urandom_range(99, 0) < 20),
            $urandom_range(3, 0), ($urandom_range(99, 0) < 10),
            ($urandom_range(99, 0) < 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
